ro_puf_sequencer: RTL and testbench

Measurement controller for the ring-oscillator PUF array. On a START request it measures every ring oscillator in turn for a fixed window:
- selects the oscillator, clears the shared edge counter, enables the oscillator, then waits for the counter to settle;
- captures each count, then compares adjacent counts to form the response word.
It owns RO selection, enable, counter clear and response formation; the RO array and the RO-clocked counter sit outside it.

---
 rtl/ro_puf_pkg.sv | 22 ++
 rtl/ro_edge_counter.sv | 23 ++
 rtl/ro_puf_sequencer.sv | 150 +++++++++++++++
 tb/tb_ro_puf_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and default sizes for the ring-oscillator PUF measurement slice.
package ro_puf_pkg;

  localparam int NUM_RO_DEF = 9;
  localparam int CNT_W_DEF  = 32;
  localparam int CHAL_W_DEF = 6;
  localparam int SEL_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    SETTLE,
    CAPTURE,
    COMPARE,
    DONE
  } state_t;

  typedef logic [CNT_W_DEF-1:0] count_t;
  typedef count_t count_arr_t [NUM_RO_DEF];

endpackage

// File: rtl/ro_edge_counter.sv
// RO-clocked edge counter: synchronous clear, gated increment, saturates at all-ones.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             count_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; holding at all-ones keeps a fast RO from wrapping to a small count.
  always_ff @(posedge count_clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ro_puf_sequencer.sv
// Steps through every ring oscillator, times its counting window, captures each count
// and forms the response word from adjacent-count comparisons.
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO        = NUM_RO_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int WINDOW_CYCLES = 16777215,
  parameter int SETTLE_CYCLES = 4,
  parameter int CHAL_W        = CHAL_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [CHAL_W-1:0] CHALLENGE,
  output logic [CHAL_W-1:0] RO_CHALLENGE,
  output logic [SEL_W-1:0]  RO_SEL,
  output logic              RO_EN,
  output logic              CNT_CLR,
  input  logic [CNT_W-1:0]  CNT_VALUE,
  output logic              BUSY,
  output logic              RESP_VALID,
  output logic [NUM_RO-2:0] RESPONSE
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   index;
  logic [WIN_W-1:0]   win_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   counts [NUM_RO];
  logic [CHAL_W-1:0]  chal_q;
  logic [NUM_RO-2:0]  resp_q;
  logic               last_ro;

  assign last_ro      = (index == SEL_W'(NUM_RO - 1));
  assign RO_SEL       = index;
  assign RO_CHALLENGE = chal_q;
  assign RESPONSE     = resp_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    BUSY       = 1'b1;
    RO_EN      = 1'b0;
    CNT_CLR    = 1'b0;
    RESP_VALID = 1'b0;
    unique case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        CNT_CLR    = 1'b1;
        state_next = MEASURE;
      end
      MEASURE: begin
        RO_EN = 1'b1;
        if (win_cnt == '0) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = last_ro ? COMPARE : CLEAR;
      end
      COMPARE: begin
        state_next = DONE;
      end
      DONE: begin
        RESP_VALID = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Both down-counters are reloaded in CLEAR so every oscillator gets an identical window.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      index      <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      chal_q     <= '0;
      resp_q     <= '0;
      for (int i = 0; i < NUM_RO; i++) begin
        counts[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            chal_q <= CHALLENGE;
            index  <= '0;
          end
        end
        CLEAR: begin
          win_cnt    <= WIN_W'(WINDOW_CYCLES - 1);
          settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
        end
        MEASURE: begin
          if (win_cnt != '0) begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        CAPTURE: begin
          for (int i = 0; i < NUM_RO; i++) begin
            if (index == SEL_W'(i)) begin
              counts[i] <= CNT_VALUE;
            end
          end
          if (!last_ro) begin
            index <= index + SEL_W'(1);
          end
        end
        COMPARE: begin
          for (int i = 0; i < NUM_RO - 1; i++) begin
            resp_q[i] <= (counts[i] > counts[i+1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer (3 ROs, 8-cycle window, 2-cycle settle) and ro_edge_counter.
module tb_ro_puf_sequencer;
  import ro_puf_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [5:0]  CHALLENGE;
  logic [5:0]  RO_CHALLENGE;
  logic [3:0]  RO_SEL;
  logic        RO_EN;
  logic        CNT_CLR;
  logic [31:0] CNT_VALUE;
  logic        BUSY;
  logic        RESP_VALID;
  logic [1:0]  RESPONSE;

  logic        ec_reset;
  logic        ec_clear;
  logic        ec_en;
  logic [3:0]  ec_count;

  count_t model_cnt [3];

  int checks = 0;
  int fails  = 0;
  int edge_n = 0;

  ro_puf_sequencer #(
    .NUM_RO(3), .CNT_W(32), .WINDOW_CYCLES(8), .SETTLE_CYCLES(2), .CHAL_W(6)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .CHALLENGE(CHALLENGE),
    .RO_CHALLENGE(RO_CHALLENGE), .RO_SEL(RO_SEL), .RO_EN(RO_EN), .CNT_CLR(CNT_CLR),
    .CNT_VALUE(CNT_VALUE), .BUSY(BUSY), .RESP_VALID(RESP_VALID), .RESPONSE(RESPONSE)
  );

  ro_edge_counter #(.CNT_W(4)) u_ec (
    .count_clk(CLK), .reset(ec_reset), .clear(ec_clear), .enable(ec_en), .count(ec_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_n <= edge_n + 1;

  // External counter model: returns the preset count for the selected oscillator.
  always_comb begin
    CNT_VALUE = 32'hDEAD_BEEF;
    case (RO_SEL)
      4'd0: CNT_VALUE = model_cnt[0];
      4'd1: CNT_VALUE = model_cnt[1];
      4'd2: CNT_VALUE = model_cnt[2];
      default: CNT_VALUE = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct { int len; int sel; bit clr_before; } pulse_t;
  pulse_t pulses[$];
  int     rv_edges[$];
  int     en_len = 0, en_sel = 0, clr_total = 0, en_total = 0;
  bit     prev_en = 0, prev_clr = 0, clr_seen = 0;

  // Records every RO_EN pulse, CNT_CLR cycle and RESP_VALID cycle (cycle = closing edge number).
  always @(negedge CLK) begin
    if (RO_EN === 1'b1 && !prev_en) begin
      en_len   = 0;
      en_sel   = int'(RO_SEL);
      clr_seen = prev_clr;
    end
    if (RO_EN === 1'b1) begin
      en_len++;
      en_total++;
      if (int'(RO_SEL) != en_sel) en_sel = -1;
    end
    if (RO_EN !== 1'b1 && prev_en) pulses.push_back('{en_len, en_sel, clr_seen});
    if (CNT_CLR === 1'b1) clr_total++;
    if (RESP_VALID === 1'b1) rv_edges.push_back(edge_n + 1);
    prev_en  = (RO_EN === 1'b1);
    prev_clr = (CNT_CLR === 1'b1);
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge with the DUT idle; returns START-to-RESP_VALID latency or -1.
  task automatic applyStimulus(input count_t c0, input count_t c1, input count_t c2,
                               input logic [5:0] chal, input bit disturb, output int latency);
    int accept;
    bit seen;
    model_cnt[0] = c0;
    model_cnt[1] = c1;
    model_cnt[2] = c2;
    CHALLENGE = chal;
    START = 1'b1;
    accept = edge_n + 1;
    @(negedge CLK);
    START = 1'b0;
    seen = 1'b0;
    latency = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (RESP_VALID === 1'b1) begin
        seen = 1'b1;
        latency = edge_n + 1 - accept;
      end else begin
        if (disturb) begin
          if (i > 2 && i < 30) begin
            START = i[0];
            CHALLENGE = 6'(i * 7);
          end else begin
            START = 1'b0;
          end
        end
        @(negedge CLK);
      end
    end
    START = 1'b0;
  endtask

  typedef struct {
    count_t c0, c1, c2;
    logic [5:0] chal;
    logic [1:0] resp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, p0, r0, clr0, en0, rv0;
    bit found;

    vecs[0] = '{32'd100, 32'd50, 32'd75, 6'h2A, 2'b01};
    vecs[1] = '{32'd40, 32'd40, 32'd40, 6'h01, 2'b00};
    vecs[2] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 6'h3F, 2'b01};
    vecs[3] = '{32'd1, 32'd2, 32'd3, 6'h12, 2'b00};
    vecs[4] = '{32'd3, 32'd2, 32'd1, 6'h07, 2'b11};
    vecs[5] = '{32'd7, 32'd9, 32'd2, 6'h20, 2'b10};
    vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 6'h15, 2'b01};

    RESET = 1'b1; START = 1'b0; CHALLENGE = 6'h3C;
    model_cnt[0] = '0; model_cnt[1] = '0; model_cnt[2] = '0;
    ec_reset = 1'b1; ec_clear = 1'b0; ec_en = 1'b0;

    repeat (3) @(negedge CLK);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_ro_en", RO_EN, 0);
    checkOutput("reset_cnt_clr", CNT_CLR, 0);
    checkOutput("reset_ro_sel", RO_SEL, 0);
    checkOutput("reset_resp_valid", RESP_VALID, 0);
    checkOutput("reset_response", RESPONSE, 0);
    checkOutput("reset_ro_challenge", RO_CHALLENGE, 0);
    RESET = 1'b0;

    while (edge_n < 9) @(negedge CLK);

    for (int v = 0; v < 7; v++) begin
      p0 = pulses.size(); r0 = rv_edges.size(); clr0 = clr_total; en0 = en_total;
      applyStimulus(vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].chal, 1'b0, lat);
      checkOutput($sformatf("v%0d_latency", v), lat, 38);
      if (v == 0) checkOutput("v0_resp_cycle", edge_n + 1, 48);
      checkOutput($sformatf("v%0d_response", v), RESPONSE, vecs[v].resp);
      checkOutput($sformatf("v%0d_ro_challenge", v), RO_CHALLENGE, vecs[v].chal);
      @(negedge CLK);
      #1;
      checkOutput($sformatf("v%0d_busy_after", v), BUSY, 0);
      checkOutput($sformatf("v%0d_rv_pulses", v), rv_edges.size() - r0, 1);
      checkOutput($sformatf("v%0d_en_pulses", v), pulses.size() - p0, 3);
      checkOutput($sformatf("v%0d_clr_cycles", v), clr_total - clr0, 3);
      checkOutput($sformatf("v%0d_en_cycles", v), en_total - en0, 24);
      if (v == 0) begin
        for (int k = 0; k < 3; k++) begin
          if (p0 + k < pulses.size()) begin
            checkOutput($sformatf("pulse%0d_len", k), pulses[p0+k].len, 8);
            checkOutput($sformatf("pulse%0d_sel", k), pulses[p0+k].sel, k);
            checkOutput($sformatf("pulse%0d_clr_before", k), pulses[p0+k].clr_before, 1);
          end
        end
      end
    end

    // START toggled and CHALLENGE changed throughout the run: one measurement only.
    r0 = rv_edges.size();
    applyStimulus(32'd3, 32'd2, 32'd1, 6'h15, 1'b1, lat);
    checkOutput("dist_latency", lat, 38);
    checkOutput("dist_ro_challenge", RO_CHALLENGE, 6'h15);
    checkOutput("dist_response", RESPONSE, 2'b11);
    repeat (4) @(negedge CLK);
    #1;
    checkOutput("dist_busy_after", BUSY, 0);
    checkOutput("dist_rv_pulses", rv_edges.size() - r0, 1);

    // Reset in the second MEASURE window.
    model_cnt[0] = 32'd9; model_cnt[1] = 32'd8; model_cnt[2] = 32'd7;
    CHALLENGE = 6'h2E;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      if (RO_SEL == 4'd1 && RO_EN === 1'b1) found = 1'b1;
    end
    checkOutput("rst_reached_measure2", found, 1);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_ro_en", RO_EN, 0);
    checkOutput("rst_response", RESPONSE, 0);
    checkOutput("rst_ro_challenge", RO_CHALLENGE, 0);
    checkOutput("rst_ro_sel", RO_SEL, 0);
    checkOutput("rst_resp_valid", RESP_VALID, 0);
    RESET = 1'b0;
    rv0 = rv_edges.size();
    repeat (40) @(negedge CLK);
    #1;
    checkOutput("rst_no_resp_valid", rv_edges.size() - rv0, 0);
    checkOutput("rst_still_idle", BUSY, 0);
    applyStimulus(32'd9, 32'd8, 32'd7, 6'h33, 1'b0, lat);
    checkOutput("rst_fresh_latency", lat, 38);
    checkOutput("rst_fresh_response", RESPONSE, 2'b11);
    checkOutput("rst_fresh_ro_challenge", RO_CHALLENGE, 6'h33);
    @(negedge CLK);

    // START held high: back-to-back measurements one IDLE cycle apart.
    model_cnt[0] = 32'd5; model_cnt[1] = 32'd6; model_cnt[2] = 32'd4;
    CHALLENGE = 6'h0F;
    r0 = rv_edges.size();
    START = 1'b1;
    p0 = edge_n + 1;
    for (int i = 0; i < 200 && (rv_edges.size() - r0) < 3; i++) begin
      @(negedge CLK);
      #1;
    end
    START = 1'b0;
    checkOutput("b2b_pulse_count", rv_edges.size() - r0, 3);
    if (rv_edges.size() - r0 >= 3) begin
      checkOutput("b2b_first_latency", rv_edges[r0] - p0, 38);
      checkOutput("b2b_gap1", rv_edges[r0+1] - rv_edges[r0], 39);
      checkOutput("b2b_gap2", rv_edges[r0+2] - rv_edges[r0+1], 39);
    end
    checkOutput("b2b_response", RESPONSE, 2'b10);
    repeat (3) @(negedge CLK);
    checkOutput("b2b_idle_after", BUSY, 0);

    // Edge counter: gated increment, hold, clear priority, saturation, reset.
    @(negedge CLK);
    ec_reset = 1'b0;
    checkOutput("ec_reset_value", ec_count, 0);
    ec_en = 1'b1;
    repeat (5) @(negedge CLK);
    checkOutput("ec_count5", ec_count, 5);
    ec_en = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("ec_hold", ec_count, 5);
    ec_en = 1'b1; ec_clear = 1'b1;
    @(negedge CLK);
    checkOutput("ec_clear", ec_count, 0);
    ec_clear = 1'b0;
    repeat (20) @(negedge CLK);
    checkOutput("ec_saturate", ec_count, 15);
    ec_reset = 1'b1;
    @(negedge CLK);
    checkOutput("ec_reset_again", ec_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
